// File: rtl/ir_pkg.sv
// Shared NEC IR definitions: state encoding, timing constants at 50 MHz, frame geometry.
// The carrier option of ir_transmit is enabled by defining IR_CARRIER_EN.
package ir_pkg;

  localparam int CNT_W      = 21;
  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = 6;

  localparam int IR_LEADER_MARK_DUR  = 450000;
  localparam int IR_LEADER_SPACE_DUR = 225000;
  localparam int IR_BIT_MARK_DUR     = 28000;
  localparam int IR_ZERO_SPACE_DUR   = 28000;
  localparam int IR_ONE_SPACE_DUR    = 84500;
  localparam int IR_GAP_DUR          = 2000000;
  localparam int IR_CARRIER_HALF     = 658;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER_MARK,
    S_LEADER_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } ir_state_e;

  function automatic logic is_mark(input ir_state_e s);
    return (s == S_LEADER_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider for the IR LED: toggles every HALF clocks, restarts high at each mark entry.
module ir_carrier_gen #(
  parameter int HALF = 658
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_mark,
  output logic o_led
);

  localparam int DIV_W = $clog2(HALF + 1);

  logic [DIV_W-1:0] r_div;
  logic             r_carrier;
  logic [DIV_W-1:0] w_div_next;
  logic             w_carrier_next;

  always_comb begin
    w_div_next     = r_div + 1'b1;
    w_carrier_next = r_carrier;
    if (i_restart) begin
      w_div_next     = '0;
      w_carrier_next = 1'b1;
    end else if (r_div == DIV_W'(HALF - 1)) begin
      w_div_next     = '0;
      w_carrier_next = ~r_carrier;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_carrier <= 1'b0;
      o_led     <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_carrier <= w_carrier_next;
      // i_mark is the next-state mark flag, so the LED lines up with the registered oIRDA.
      o_led     <= w_carrier_next & i_mark;
    end
  end

endmodule

// File: rtl/ir_transmit.sv
// NEC IR frame generator: leader, 32 pulse-distance bits LSB first, stop mark, gap.
// Define IR_CARRIER_EN to add the modulated oIR_LED output.
module ir_transmit
  import ir_pkg::*;
#(
  parameter int LEADER_MARK_DUR  = IR_LEADER_MARK_DUR,
  parameter int LEADER_SPACE_DUR = IR_LEADER_SPACE_DUR,
  parameter int BIT_MARK_DUR     = IR_BIT_MARK_DUR,
  parameter int ZERO_SPACE_DUR   = IR_ZERO_SPACE_DUR,
  parameter int ONE_SPACE_DUR    = IR_ONE_SPACE_DUR,
  parameter int GAP_DUR          = IR_GAP_DUR
`ifdef IR_CARRIER_EN
  , parameter int CARRIER_HALF   = IR_CARRIER_HALF
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iSTART,
  input  logic [31:0] iDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oIRDA
`ifdef IR_CARRIER_EN
  , output logic      oIR_LED
`endif
);

  ir_state_e              r_state;
  ir_state_e              w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [31:0]            r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]       w_dur;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_irda_next;
  logic                   w_busy_next;
  logic                   w_done_next;

  assign w_accept = (r_state == S_IDLE) && iSTART;
  assign w_last   = (r_cnt == w_dur - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_dur        = '0;
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:         if (iSTART) w_state_next = S_LEADER_MARK;
      S_LEADER_MARK: begin
        w_dur = CNT_W'(LEADER_MARK_DUR);
        if (w_last) w_state_next = S_LEADER_SPACE;
      end
      S_LEADER_SPACE: begin
        w_dur = CNT_W'(LEADER_SPACE_DUR);
        if (w_last) w_state_next = S_BIT_MARK;
      end
      S_BIT_MARK: begin
        w_dur = CNT_W'(BIT_MARK_DUR);
        if (w_last) w_state_next = S_BIT_SPACE;
      end
      S_BIT_SPACE: begin
        w_dur = r_shift[0] ? CNT_W'(ONE_SPACE_DUR) : CNT_W'(ZERO_SPACE_DUR);
        if (w_last)
          w_state_next = (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
      end
      S_STOP_MARK: begin
        w_dur = CNT_W'(BIT_MARK_DUR);
        if (w_last) w_state_next = S_GAP;
      end
      S_GAP: begin
        w_dur = CNT_W'(GAP_DUR);
        if (w_last) w_state_next = S_IDLE;
      end
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_irda_next = ~is_mark(w_state_next);
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (r_state == S_GAP) && w_last;
  end

  // NOTE: only control and datapath flops are reset here; there is no memory array to leave unreset.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      oIRDA     <= 1'b1;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      if (w_state_next != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE)  r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_shift   <= iDATA;
        r_bit_cnt <= '0;
      end else if (r_state == S_BIT_SPACE && w_last) begin
        r_shift   <= {1'b0, r_shift[31:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      oIRDA <= w_irda_next;
      oBUSY <= w_busy_next;
      oDONE <= w_done_next;
    end
  end

`ifdef IR_CARRIER_EN
  logic w_mark_restart;
  assign w_mark_restart = is_mark(w_state_next) && !is_mark(r_state);

  ir_carrier_gen #(.HALF(CARRIER_HALF)) u_carrier (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .i_restart (w_mark_restart),
    .i_mark    (is_mark(w_state_next)),
    .o_led     (oIR_LED)
  );
`endif

endmodule

// File: tb/tb_ir_transmit.sv
// Directed bench for ir_transmit with shortened durations; decodes the line back into a word.
`timescale 1ns/1ps
module tb_ir_transmit;

  localparam int LM  = 40;
  localparam int LS  = 20;
  localparam int BM  = 4;
  localparam int ZS  = 4;
  localparam int OS  = 12;
  localparam int GAP = 30;
  localparam int CH  = 3;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iSTART;
  logic [31:0] iDATA;
  logic        oBUSY;
  logic        oDONE;
  logic        oIRDA;
`ifdef IR_CARRIER_EN
  logic        oIR_LED;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 iCLK = ~iCLK;

  ir_transmit #(
    .LEADER_MARK_DUR  (LM),
    .LEADER_SPACE_DUR (LS),
    .BIT_MARK_DUR     (BM),
    .ZERO_SPACE_DUR   (ZS),
    .ONE_SPACE_DUR    (OS),
    .GAP_DUR          (GAP)
`ifdef IR_CARRIER_EN
    , .CARRIER_HALF   (CH)
`endif
  ) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iSTART (iSTART),
    .iDATA  (iDATA),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oIRDA  (oIRDA)
`ifdef IR_CARRIER_EN
    , .oIR_LED (oIR_LED)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Length of the run of level lvl starting at the current negedge; ends on the first differing sample.
  task automatic measure(input logic lvl, input int max_len, output int got);
    int n = 0;
    while (oIRDA === lvl && n < max_len + 64) begin
`ifdef IR_CARRIER_EN
      check("led", {63'd0, oIR_LED}, (lvl == 1'b0 && ((n / CH) % 2) == 0) ? 64'd1 : 64'd0);
`endif
      n++;
      @(negedge iCLK);
    end
    got = n;
  endtask

  // Starts at the first busy cycle; with nbits < 32 it stops at the start of that bit's mark.
  task automatic check_frame(input logic [31:0] word, input int nbits, output int total);
    int          got;
    logic [31:0] dec = '0;
    total = 0;
    measure(1'b0, LM, got); check("leader_mark", got, LM); total += got;
    measure(1'b1, LS, got); check("leader_space", got, LS); total += got;
    for (int i = 0; i < nbits; i++) begin
      measure(1'b0, BM, got); check($sformatf("bit%0d_mark", i), got, BM); total += got;
      measure(1'b1, OS, got); check($sformatf("bit%0d_space", i), got, word[i] ? OS : ZS);
      total += got;
      dec[i] = (got > (OS + ZS) / 2);
    end
    if (nbits == 32) begin
      check("decoded_word", dec, word);
      measure(1'b0, BM, got); check("stop_mark", got, BM); total += got;
      got = 0;
      while (oDONE !== 1'b1 && got < GAP + 64) begin
        got++;
        @(negedge iCLK);
      end
      check("gap_len", got, GAP); total += got;
      check("done_pulse", {63'd0, oDONE}, 64'd1);
      check("busy_low_at_done", {63'd0, oBUSY}, 64'd0);
      check("busy_time", total,
            LM + LS + 32 * BM + $countones(word) * OS + (32 - $countones(word)) * ZS + BM + GAP);
    end
  endtask

  task automatic start_frame(input logic [31:0] word);
    iDATA  = word;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    check("busy_after_accept", {63'd0, oBUSY}, 64'd1);
    check("irda_after_accept", {63'd0, oIRDA}, 64'd0);
  endtask

  initial begin
    int total;
    int dones;
    iRST_n = 1'b0;
    iSTART = 1'b0;
    iDATA  = '0;
    repeat (2) @(negedge iCLK);
    check("rst_irda", {63'd0, oIRDA}, 64'd1);
    check("rst_busy", {63'd0, oBUSY}, 64'd0);
    check("rst_done", {63'd0, oDONE}, 64'd0);
    iRST_n = 1'b1;
    repeat (3) @(negedge iCLK);
    check("idle_irda", {63'd0, oIRDA}, 64'd1);
    check("idle_busy", {63'd0, oBUSY}, 64'd0);

    // Single frame, and the second loopback word
    start_frame(32'hE11E00FF);
    check_frame(32'hE11E00FF, 32, total);
    @(negedge iCLK);
    check("done_one_cycle", {63'd0, oDONE}, 64'd0);
    start_frame(32'h00FFF708);
    check_frame(32'h00FFF708, 32, total);
    @(negedge iCLK);

    // Busy rejection: iSTART held, iDATA changed; second frame starts from the oDONE cycle
    iDATA  = 32'hF30C8877;
    iSTART = 1'b1;
    @(negedge iCLK);
    iDATA  = 32'h0000A5C3;
    check_frame(32'hF30C8877, 32, total);
    @(negedge iCLK);
    iSTART = 1'b0;
    check("b2b_busy", {63'd0, oBUSY}, 64'd1);
    check("b2b_irda", {63'd0, oIRDA}, 64'd0);
    check_frame(32'h0000A5C3, 32, total);
    @(negedge iCLK);

    // Reset during bit 10's mark
    start_frame(32'hFFFFFFFF);
    check_frame(32'hFFFFFFFF, 10, total);
    @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    check("midrst_irda", {63'd0, oIRDA}, 64'd1);
    check("midrst_busy", {63'd0, oBUSY}, 64'd0);
    check("midrst_done", {63'd0, oDONE}, 64'd0);
`ifdef IR_CARRIER_EN
    check("midrst_led", {63'd0, oIR_LED}, 64'd0);
`endif
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    dones = 0;
    for (int i = 0; i < LM + GAP; i++) begin
      @(negedge iCLK);
      if (oDONE === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle_busy", {63'd0, oBUSY}, 64'd0);
    start_frame(32'h1234EDCB);
    check_frame(32'h1234EDCB, 32, total);
    @(negedge iCLK);

    // All-zero word: 40 + 20 + 64*4 + 4 + 30
    start_frame(32'h00000000);
    check_frame(32'h00000000, 32, total);
    check("zero_busy_total", total, 350);
    @(negedge iCLK);
    check("final_idle_irda", {63'd0, oIRDA}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
